// File: rtl/fifo_rd_serializer.sv
// Pops WIDTH-bit words from an upstream sync FIFO and streams each one out as
// RATIO consecutive OUT_WIDTH-bit slices on a valid/ready interface.
module fifo_rd_serializer #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit MSB_FIRST = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_dout,
   output logic                 fifo_pop,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_last,
   output logic                 busy,
   output logic [CNT_W-1:0]     word_cnt
);

   localparam int RATIO = WIDTH / OUT_WIDTH;
   localparam int IDX_W = $clog2(RATIO);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   typedef enum logic {
      EMPTY,
      DRAIN
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [WIDTH-1:0]     hold_reg;
   logic [IDX_W-1:0]     sel;
   logic [OUT_WIDTH-1:0] slices [RATIO];
   logic                 at_last;
   logic                 take;

   assign m_valid = (state == DRAIN);
   assign busy    = m_valid;
   assign at_last = (idx == LAST_IDX);
   assign take    = m_valid && m_ready;
   assign m_last  = m_valid && at_last;

   // Refill in the same cycle the final slice leaves, so words stream without a bubble.
   assign fifo_pop = rstn && !flush && !fifo_empty &&
                     ((state == EMPTY) || (take && at_last));

   for (genvar i = 0; i < RATIO; i++) begin : g_slice
      assign slices[i] = hold_reg[i*OUT_WIDTH +: OUT_WIDTH];
   end

   assign sel    = MSB_FIRST ? (LAST_IDX - idx) : idx;
   assign m_data = slices[sel];

   // Flush outranks everything; otherwise a load on pop overrides the end-of-word return to EMPTY.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= EMPTY;
         idx      <= '0;
         hold_reg <= '0;
         word_cnt <= '0;
      end else if (flush) begin
         state <= EMPTY;
         idx   <= '0;
      end else begin
         if (take) begin
            if (at_last) begin
               word_cnt <= word_cnt + 1'b1;
               state    <= EMPTY;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if (fifo_pop) begin
            hold_reg <= fifo_dout;
            idx      <= '0;
            state    <= DRAIN;
         end
      end
   end

endmodule
